// File: rtl/display_pkg.sv
// Shared types and constants for the decimal seven-segment display path.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // ceil(w * log10(2)) in integer arithmetic; w*log10(2) is never an exact integer
  function automatic int nbcd(input int w);
    return int'((longint'(w) * 64'd30103 + 64'd99999) / 64'd100000);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit to an active-low g..a seven-segment pattern; codes above 9 blank.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/decimal_display.sv
// Signed binary to blanked decimal on active-low seven-segment digits, using a
// double-dabble sequencer; the displayed result only changes when a conversion commits.
module decimal_display
  import display_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  on3,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int NB = nbcd(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [7*DIGITS-1:0] SEGS_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};

  state_t                state_q;
  logic [4*NB-1:0]       bcd_q, bcd_d, bcdAdj;
  logic [WIDTH-1:0]      mag_q, mag_d, magIn;
  logic                  sign_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q, done_q, ovf_q, ovf_d;
  logic [7*DIGITS-1:0]   segs_q, segs_d;
  logic [6:0]            glyph [DIGITS];
  int                    sigDigits;

  assign magIn = value_in[WIDTH-1] ? (-value_in) : value_in;

  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, mag_d} = {bcdAdj, mag_q} << 1;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : gPos
    if (k < NB) begin : gDigit
      bcd_to_seg uSeg (
        .bcd_i (bcd_q[4*k +: 4]),
        .seg_o (glyph[k])
      );
    end else begin : gNone
      assign glyph[k] = SEG_BLANK;
    end
  end

  // Leading-zero blanking, sign placement and overflow from the finished BCD value
  always_comb begin
    sigDigits = 1;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) sigDigits = i + 1;
    end
    ovf_d  = (sigDigits > DIGITS) || (sign_q && (sigDigits + 1 > DIGITS));
    segs_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_d)                        segs_d[7*k +: 7] = SEG_MINUS;
      else if (k < sigDigits)           segs_d[7*k +: 7] = glyph[k];
      else if (sign_q && k == sigDigits) segs_d[7*k +: 7] = SEG_MINUS;
      else                              segs_d[7*k +: 7] = SEG_BLANK;
    end
  end

  // A load in any state restarts the conversion; only COMMIT touches the display
  always_ff @(posedge on3 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      segs_q  <= SEGS_RESET;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q <= SHIFT;
        bcd_q   <= '0;
        mag_q   <= magIn;
        sign_q  <= value_in[WIDTH-1];
        cnt_q   <= '0;
        busy_q  <= (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          SHIFT: begin
            bcd_q  <= bcd_d;
            mag_q  <= mag_d;
            cnt_q  <= cnt_q + 1'b1;
            busy_q <= 1'b1;
            if (cnt_q == LAST_CNT) state_q <= COMMIT;
          end
          COMMIT: begin
            segs_q  <= segs_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign segs     = segs_q;

endmodule

// File: tb/tb_decimal_display.sv
// Randomised and directed bench for decimal_display against a string-based decimal model.
module tb_decimal_display;

  localparam int WIDTH   = 32;
  localparam int DIGITS  = 8;
  localparam int LATENCY = WIDTH + 1;

  logic                on3;
  logic                reset;
  logic                load;
  logic [WIDTH-1:0]    value_in;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [7*DIGITS-1:0] segs;

  int assertions = 0;
  int failures   = 0;

  decimal_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .on3      (on3),
    .reset    (reset),
    .load     (load),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .segs     (segs)
  );

  initial on3 = 1'b0;
  always #5 on3 = ~on3;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] glyphOf(input byte c);
    logic [6:0] font [10];
    font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (c == "-") return 7'b0111111;
    return font[c - "0"];
  endfunction

  // Reference: print the value in decimal, then right-align the text on the display
  task automatic modelDisplay(input logic [WIDTH-1:0] v, output logic [7*DIGITS-1:0] s, output logic ov);
    longint val;
    string  txt;
    int     len;
    val = longint'($signed(v));
    txt = $sformatf("%0d", val);
    len = txt.len();
    ov  = (len > DIGITS);
    for (int k = 0; k < DIGITS; k++) begin
      if (ov)           s[7*k +: 7] = 7'b0111111;
      else if (k < len) s[7*k +: 7] = glyphOf(txt[len-1-k]);
      else              s[7*k +: 7] = 7'b1111111;
    end
  endtask

  task automatic tick();
    @(posedge on3);
    #1;
  endtask

  // Load first, optionally restart with second at cycle abortAt, and check until commit
  task automatic applyStimulus(input logic [WIDTH-1:0] first, input bit doAbort,
                               input int abortAt, input logic [WIDTH-1:0] second);
    logic [7*DIGITS-1:0] oldSegs, expSegs;
    logic                oldOvf, expOvf;
    logic [WIDTH-1:0]    target;
    int                  doneAt;
    oldSegs = segs;
    oldOvf  = overflow;
    target  = first;
    doneAt  = doAbort ? abortAt + LATENCY : LATENCY;
    value_in = first;
    load     = 1'b1;
    tick();
    load = 1'b0;
    checkOutput("done after load", 64'(done), 64'd0);
    for (int c = 1; c <= doneAt; c++) begin
      if (doAbort && c == abortAt) begin
        value_in = second;
        load     = 1'b1;
        target   = second;
      end
      tick();
      load = 1'b0;
      if (c < doneAt) begin
        checkOutput("busy during conversion", 64'(busy), 64'd1);
        checkOutput("done early", 64'(done), 64'd0);
        checkOutput("segs held", 64'(segs), 64'(oldSegs));
        checkOutput("overflow held", 64'(overflow), 64'(oldOvf));
      end else begin
        modelDisplay(target, expSegs, expOvf);
        checkOutput($sformatf("done for %0d", $signed(target)), 64'(done), 64'd1);
        checkOutput($sformatf("busy at done %0d", $signed(target)), 64'(busy), 64'd0);
        checkOutput($sformatf("segs for %0d", $signed(target)), 64'(segs), 64'(expSegs));
        checkOutput($sformatf("overflow for %0d", $signed(target)), 64'(overflow), 64'(expOvf));
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " done"}, 64'(done), 64'd0);
    checkOutput({tag, " overflow"}, 64'(overflow), 64'd0);
    checkOutput({tag, " segs"}, 64'(segs), 64'({{(DIGITS-1){7'b1111111}}, 7'b1000000}));
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    longint           p;
    int               doneSeen;
    reset    = 1'b1;
    load     = 1'b0;
    value_in = '0;
    #12;
    checkResetState("reset");
    @(negedge on3);
    reset = 1'b0;
    tick();

    applyStimulus(32'd1234, 1'b0, 0, '0);
    applyStimulus(-32'sd56, 1'b0, 0, '0);
    applyStimulus(32'd0, 1'b0, 0, '0);
    applyStimulus(32'd99999999, 1'b0, 0, '0);
    applyStimulus(32'd100000000, 1'b0, 0, '0);
    applyStimulus(-32'sd9999999, 1'b0, 0, '0);
    applyStimulus(-32'sd10000000, 1'b0, 0, '0);
    applyStimulus(32'h8000_0000, 1'b0, 0, '0);
    applyStimulus(32'd800, 1'b1, 10, 32'd7);
    applyStimulus(32'd5, 1'b1, 33, 32'hFFFF_FFFF);

    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom();
        1: v = 32'($urandom_range(0, 99999999));
        2: v = 32'(0 - $urandom_range(0, 9999999));
        default: begin
          p = 1;
          for (int e = $urandom_range(0, 9); e > 0; e--) p = p * 10;
          v = 32'(p - 1 + longint'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) v = -v;
        end
      endcase
      applyStimulus(v, 1'b0, 0, '0);
    end

    value_in = 32'd4321;
    load     = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2;
    reset = 1'b1;
    #1;
    checkResetState("mid-run reset");
    @(negedge on3);
    reset = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("no done after reset", 64'(doneSeen), 64'd0);
    checkResetState("idle after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
